// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: queues fetch-time branch predictions in program order,
// checks each one against the resolved outcome, drives the BTB update port and
// issues a fetch redirect (plus a wrong-path squash) on a mispredict.
// Optional feature macro: BRU_STATS_EN adds resolve/mispredict counters;
// without it stat_branches and stat_mispredicts are tied to 0.
// Handshake: pred_push and res_valid are single-cycle qualifiers sampled on the
// rising edge while in RUN; there is no back-pressure beyond pred_full, and both
// are ignored while the unit is flushing the wrong path.
module branch_resolution_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        bru_clk,
  input  logic        bru_reset_n,
  input  logic        pred_push,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_full,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        btb_write,
  output logic        btb_branch_taken,
  output logic [31:0] btb_new_pc,
  output logic [31:0] btb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        res_error,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
  output logic        dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [PW:0]   DEPTH_CNT = DEPTH[PW:0];
  localparam logic [CW-1:0] FLUSH_LD  = FLUSH_CYCLES[CW-1:0];

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [31:0]   fifo_tgt_q [DEPTH];
  logic [31:0]   fifo_tgt_d [DEPTH];
  logic          fifo_tkn_q [DEPTH];
  logic          fifo_tkn_d [DEPTH];

  logic        pred_full_q, pred_full_d;
  logic        btb_write_q, btb_write_d;
  logic        btb_taken_q, btb_taken_d;
  logic [31:0] btb_new_pc_q, btb_new_pc_d;
  logic [31:0] btb_data_q, btb_data_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        res_error_q, res_error_d;

  logic        resolve_acc, mispredict, pc_mismatch, do_pop, do_push;
  logic [31:0] head_pc, head_tgt;
  logic        head_tkn;

  assign head_pc  = fifo_pc_q[rd_ptr_q];
  assign head_tgt = fifo_tgt_q[rd_ptr_q];
  assign head_tkn = fifo_tkn_q[rd_ptr_q];

  // Next-state: FSM, FIFO bookkeeping, resolve compare and BTB/redirect outputs
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    fifo_pc_d        = fifo_pc_q;
    fifo_tgt_d       = fifo_tgt_q;
    fifo_tkn_d       = fifo_tkn_q;
    btb_write_d      = 1'b0;
    btb_taken_d      = btb_taken_q;
    btb_new_pc_d     = btb_new_pc_q;
    btb_data_d       = btb_data_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    res_error_d      = 1'b0;
    resolve_acc      = 1'b0;
    mispredict       = 1'b0;
    pc_mismatch      = 1'b0;
    do_pop           = 1'b0;
    do_push          = 1'b0;
    case (state_q)
      ST_RUN: begin
        resolve_acc = res_valid;
        if (resolve_acc) begin
          if (count_q == '0) begin
            // Nothing queued: treat as a not-taken prediction for an unknown branch
            res_error_d = 1'b1;
            mispredict  = res_taken;
          end else begin
            do_pop      = 1'b1;
            pc_mismatch = (head_pc != res_pc);
            res_error_d = pc_mismatch;
            mispredict  = (head_tkn != res_taken) |
                          (res_taken & (head_tgt != res_target)) | pc_mismatch;
          end
          btb_write_d  = 1'b1;
          btb_new_pc_d = res_pc;
          btb_data_d   = res_target;
          btb_taken_d  = res_taken;
          if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = res_taken ? res_target : (res_pc + 32'd4);
          end
        end
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = pred_push & ((count_q != DEPTH_CNT) | do_pop);
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push) begin
          fifo_pc_d[wr_ptr_q]  = pred_pc;
          fifo_tgt_d[wr_ptr_q] = pred_target;
          fifo_tkn_d[wr_ptr_q] = pred_taken;
          wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        // Everything still queued (including this cycle's push) is wrong-path
        if (mispredict) begin
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LD;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q <= 1) begin
          flush_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
    pred_full_d = (count_d == DEPTH_CNT);
  end

  // State and output registers, all cleared asynchronously
  always_ff @(posedge bru_clk or negedge bru_reset_n) begin
    if (!bru_reset_n) begin
      state_q          <= ST_RUN;
      flush_cnt_q      <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]  <= '0;
        fifo_tgt_q[i] <= '0;
        fifo_tkn_q[i] <= 1'b0;
      end
      pred_full_q      <= 1'b0;
      btb_write_q      <= 1'b0;
      btb_taken_q      <= 1'b0;
      btb_new_pc_q     <= '0;
      btb_data_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      res_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      fifo_pc_q        <= fifo_pc_d;
      fifo_tgt_q       <= fifo_tgt_d;
      fifo_tkn_q       <= fifo_tkn_d;
      pred_full_q      <= pred_full_d;
      btb_write_q      <= btb_write_d;
      btb_taken_q      <= btb_taken_d;
      btb_new_pc_q     <= btb_new_pc_d;
      btb_data_q       <= btb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      res_error_q      <= res_error_d;
    end
  end

  assign pred_full        = pred_full_q;
  assign btb_write        = btb_write_q;
  assign btb_branch_taken = btb_taken_q;
  assign btb_new_pc       = btb_new_pc_q;
  assign btb_data         = btb_data_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign res_error        = res_error_q;
  assign dbg_state        = (state_q == ST_FLUSH);

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;

  // Counters advance alongside the btb_write they describe, wrapping on overflow
  always_comb begin
    stat_br_d  = stat_br_q + {31'd0, resolve_acc};
    stat_mis_d = stat_mis_q + {31'd0, mispredict};
  end

  // Counter registers
  always_ff @(posedge bru_clk or negedge bru_reset_n) begin
    if (!bru_reset_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Testbench for branch_resolution_unit: scenario tasks driven from one initial
// block, a prediction-FIFO model feeding an expected-update queue, and a
// scoreboard process that pops one expectation per btb_write.
module tb_branch_resolution_unit;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        bru_clk = 1'b0;
  logic        bru_reset_n = 1'b0;
  logic        pred_push = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0, res_pc = '0, res_target = '0;
  logic        pred_full, btb_write, btb_branch_taken, redirect_valid, res_error, dbg_state;
  logic [31:0] btb_new_pc, btb_data, redirect_pc, stat_branches, stat_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {logic [31:0] pc; logic taken; logic [31:0] target;} pred_t;
  typedef struct {logic [31:0] new_pc; logic [31:0] data; logic taken; logic redir;
                  logic [31:0] redir_pc; logic err;} exp_t;

  pred_t       mdl_fifo[$];
  exp_t        exp_q[$];
  int          mdl_flush = 0;
  logic [31:0] mdl_branches = '0, mdl_mis = '0;
  exp_t        mon_e;

  branch_resolution_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .bru_clk(bru_clk), .bru_reset_n(bru_reset_n),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_full(pred_full),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .btb_write(btb_write), .btb_branch_taken(btb_branch_taken), .btb_new_pc(btb_new_pc),
    .btb_data(btb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .res_error(res_error), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 bru_clk = ~bru_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mdl_fifo.delete();
    exp_q.delete();
    mdl_flush    = 0;
    mdl_branches = '0;
    mdl_mis      = '0;
  endtask

  task automatic idle_inputs();
    pred_push = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
  endtask

  // driver: one clock of stimulus, model advanced for that edge; returns 1ns after it
  task automatic drive(input logic push, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtg);
    exp_t  e;
    pred_t h;
    logic  mis, err;
    @(negedge bru_clk);
    pred_push = push; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    if (mdl_flush > 0) begin
      mdl_flush--;
    end else begin
      mis = 1'b0;
      err = 1'b0;
      if (rv) begin
        if (mdl_fifo.size() == 0) begin
          err = 1'b1;
          mis = rt;
        end else begin
          h   = mdl_fifo.pop_front();
          err = (h.pc != rpc);
          mis = (h.taken != rt) || (rt && (h.target != rtg)) || err;
        end
        e.new_pc   = rpc;
        e.data     = rtg;
        e.taken    = rt;
        e.redir    = mis;
        e.redir_pc = rt ? rtg : rpc + 32'd4;
        e.err      = err;
        exp_q.push_back(e);
        mdl_branches = mdl_branches + 32'd1;
        if (mis) mdl_mis = mdl_mis + 32'd1;
      end
      if (push && !mis && mdl_fifo.size() < DEPTH) mdl_fifo.push_back('{ppc, pt, ptg});
      if (mis) begin
        mdl_fifo.delete();
        mdl_flush = FLUSH_CYCLES;
      end
    end
    @(posedge bru_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  // scoreboard: every btb_write must match the oldest expected update
  always @(posedge bru_clk) begin
    #2;
    if (bru_reset_n) begin
      vectors++;
      if (btb_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_write: btb_write=1 new_pc=%h, no update expected", btb_new_pc);
        end else begin
          mon_e = exp_q.pop_front();
          if ({btb_new_pc, btb_data, btb_branch_taken, redirect_valid, res_error} !==
              {mon_e.new_pc, mon_e.data, mon_e.taken, mon_e.redir, mon_e.err} ||
              (mon_e.redir && redirect_pc !== mon_e.redir_pc)) begin
            miscompares++;
            $display("FAIL sb_update: got pc=%h data=%h tk=%b rv=%b rpc=%h err=%b expected pc=%h data=%h tk=%b rv=%b rpc=%h err=%b",
                     btb_new_pc, btb_data, btb_branch_taken, redirect_valid, redirect_pc, res_error,
                     mon_e.new_pc, mon_e.data, mon_e.taken, mon_e.redir, mon_e.redir_pc, mon_e.err);
          end
        end
      end else if (redirect_valid !== 1'b0 || res_error !== 1'b0 || btb_write !== 1'b0) begin
        miscompares++;
        $display("FAIL sb_stray_pulse: btb_write=%b redirect_valid=%b res_error=%b expected 0 0 0",
                 btb_write, redirect_valid, res_error);
      end
    end
  end

  task automatic check_all_zero(input string name);
    vectors++;
    if ({pred_full, btb_write, btb_branch_taken, btb_new_pc, btb_data, redirect_valid,
         redirect_pc, res_error, stat_branches, stat_mispredicts, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs not all zero full=%b wr=%b pc=%h data=%h rv=%b rpc=%h err=%b sb=%h sm=%h st=%b",
               name, pred_full, btb_write, btb_new_pc, btb_data, redirect_valid, redirect_pc,
               res_error, stat_branches, stat_mispredicts, dbg_state);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bru_reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge bru_clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge bru_clk);
    bru_reset_n = 1'b1;
  endtask

  task automatic test_correct_predict();
    drive(1, 32'h100, 1, 32'h200, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 1, 32'h100, 1, 32'h200);
    vectors++;
    if ({btb_write, btb_new_pc, btb_data, btb_branch_taken, redirect_valid} !==
        {1'b1, 32'h100, 32'h200, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL correct_predict: got wr=%b pc=%h data=%h tk=%b rv=%b expected 1 100 200 1 0",
               btb_write, btb_new_pc, btb_data, btb_branch_taken, redirect_valid);
    end
    idle(1);
  endtask

  task automatic test_mispredict_flush();
    drive(1, 32'h100, 0, 32'h0, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 1, 32'h100, 1, 32'h300);
    vectors++;
    if ({redirect_valid, redirect_pc, dbg_state} !== {1'b1, 32'h300, 1'b1}) begin
      miscompares++;
      $display("FAIL mispredict_redirect: got rv=%b rpc=%h flush=%b expected 1 00000300 1",
               redirect_valid, redirect_pc, dbg_state);
    end
    vectors++;
`ifdef BRU_STATS_EN
    if ({stat_branches, stat_mispredicts} !== {32'd2, 32'd1}) begin
`else
    if ({stat_branches, stat_mispredicts} !== {32'd0, 32'd0}) begin
`endif
      miscompares++;
      $display("FAIL stats_after_1_2: got branches=%0d mispredicts=%0d", stat_branches, stat_mispredicts);
    end
    drive(1, 32'h500, 0, 32'h0, 1, 32'h500, 0, 32'h0);
    vectors++;
    if (dbg_state !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hold: got state=%b expected 1", dbg_state);
    end
    drive(1, 32'h504, 0, 32'h0, 0, '0, 0, '0);
    vectors++;
    if ({dbg_state, pred_full} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_exit: got state=%b full=%b expected 0 0", dbg_state, pred_full);
    end
    // FIFO must be empty: this resolve has nothing to pop
    drive(0, '0, 0, '0, 1, 32'h500, 0, 32'h0);
    vectors++;
    if ({btb_write, res_error, redirect_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL flush_dropped_pushes: got wr=%b err=%b rv=%b expected 1 1 0",
               btb_write, res_error, redirect_valid);
    end
    idle(1);
  endtask

  task automatic test_pc_wrap();
    drive(1, 32'hFFFF_FFFC, 1, 32'h200, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 1, 32'hFFFF_FFFC, 0, 32'hDEAD_BEEF);
    vectors++;
    if ({redirect_valid, redirect_pc, res_error} !== {1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL pc_wrap: got rv=%b rpc=%h err=%b expected 1 00000000 0",
               redirect_valid, redirect_pc, res_error);
    end
    idle(FLUSH_CYCLES);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      drive(1, 32'h1000 + 32'(i * 4), 1'(i % 2), 32'h2000 + 32'(i), 0, '0, 0, '0);
    vectors++;
    if (pred_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_set: got pred_full=%b expected 1", pred_full);
    end
    drive(1, 32'h1FFC, 1, 32'h3000, 0, '0, 0, '0);
    vectors++;
    if (pred_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drop: got pred_full=%b expected 1", pred_full);
    end
    drive(1, 32'h1010, 0, 32'h2004, 1, 32'h1000, 0, 32'h2000);
    vectors++;
    if ({pred_full, btb_write, btb_new_pc} !== {1'b1, 1'b1, 32'h1000}) begin
      miscompares++;
      $display("FAIL full_push_pop: got full=%b wr=%b pc=%h expected 1 1 00001000",
               pred_full, btb_write, btb_new_pc);
    end
    for (int i = 0; i < DEPTH; i++)
      drive(0, '0, 0, '0, 1, mdl_fifo[0].pc, mdl_fifo[0].taken, mdl_fifo[0].target);
    vectors++;
    if ({pred_full, btb_new_pc, redirect_valid} !== {1'b0, 32'h1010, 1'b0}) begin
      miscompares++;
      $display("FAIL full_drain_order: got full=%b last_pc=%h rv=%b expected 0 00001010 0",
               pred_full, btb_new_pc, redirect_valid);
    end
    idle(1);
  endtask

  task automatic test_empty_resolve();
    drive(0, '0, 0, '0, 1, 32'h80, 1, 32'h40);
    vectors++;
    if ({btb_write, res_error, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL empty_resolve: got wr=%b err=%b rv=%b rpc=%h expected 1 1 1 00000040",
               btb_write, res_error, redirect_valid, redirect_pc);
    end
    idle(FLUSH_CYCLES);
  endtask

  task automatic test_reset_mid_flush();
    drive(1, 32'h300, 1, 32'h400, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 1, 32'h300, 0, 32'h0);
    @(negedge bru_clk);
    idle_inputs();
    #2;
    bru_reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_mid_flush");
    @(posedge bru_clk);
    @(negedge bru_clk);
    #1;
    bru_reset_n = 1'b1;
    drive(1, 32'h600, 1, 32'h700, 0, '0, 0, '0);
    drive(0, '0, 0, '0, 1, 32'h600, 1, 32'h700);
    vectors++;
    if ({btb_write, btb_new_pc, redirect_valid, dbg_state} !== {1'b1, 32'h600, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL resolve_after_reset: got wr=%b pc=%h rv=%b st=%b expected 1 00000600 0 0",
               btb_write, btb_new_pc, redirect_valid, dbg_state);
    end
    idle(1);
  endtask

  task automatic test_random();
    logic        push, rv, rt;
    logic [31:0] ppc, rpc, rtg;
    for (int n = 0; n < 400; n++) begin
      push = ($urandom_range(0, 1) == 1);
      rv   = ($urandom_range(0, 9) < 4);
      ppc  = {$urandom_range(0, 32'hFFFF), 2'b00} ;
      rpc  = {$urandom_range(0, 32'hFF), 2'b00};
      rt   = 1'($urandom_range(0, 1));
      rtg  = {$urandom_range(0, 32'hFF), 2'b00};
      if (mdl_flush == 0 && mdl_fifo.size() > 0) begin
        if ($urandom_range(0, 9) != 0) rpc = mdl_fifo[0].pc;
        rt = ($urandom_range(0, 4) != 0) ? mdl_fifo[0].taken : ~mdl_fifo[0].taken;
        if ($urandom_range(0, 6) != 0) rtg = mdl_fifo[0].target;
      end
      drive(push, ppc, 1'($urandom_range(0, 1)), {$urandom_range(0, 32'hFF), 2'b00},
            rv, rpc, rt, rtg);
      vectors++;
      if ({pred_full, dbg_state} !== {mdl_fifo.size() == DEPTH, mdl_flush > 0}) begin
        miscompares++;
        $display("FAIL random_state: got full=%b flush=%b expected %b %b",
                 pred_full, dbg_state, mdl_fifo.size() == DEPTH, mdl_flush > 0);
      end
    end
    idle(FLUSH_CYCLES + 1);
    vectors++;
`ifdef BRU_STATS_EN
    if ({stat_branches, stat_mispredicts} !== {mdl_branches, mdl_mis}) begin
`else
    if ({stat_branches, stat_mispredicts} !== {32'd0, 32'd0}) begin
`endif
      miscompares++;
      $display("FAIL random_stats: got branches=%0d mispredicts=%0d model %0d %0d",
               stat_branches, stat_mispredicts, mdl_branches, mdl_mis);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_missing_writes: got %0d updates never written, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_flush();
    test_pc_wrap();
    test_full();
    test_empty_resolve();
    test_reset_mid_flush();
    test_random();
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
